tmr_fault_monitor: RTL and testbench
====================================

Name: tmr_fault_monitor

Overview:
Sits directly downstream of the 64-bit TMR voter on the MI-V MTIME path. It consumes the voter's registered voted value, disagreement flag and per-lane fault flags. It tracks per-lane fault statistics, declares a lane failed after persistent faults, and sequences the TMR health state NORMAL/DEGRADED/FAILED. It also checks that the voted MTIME advances legally and raises a level interrupt to the system.

Parameters:
CNT_W, 16, width of each per-lane saturating fault counter
PERSIST_THRESH, 4, consecutive faulting cycles before a lane is declared failed (must be ≥1)
RUN_W, 8, width of per-lane consecutive-run counter (2^RUN_W-1 ≥ PERSIST_THRESH)

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  asynchronous active-low reset
voted_value  in  64  voter majority output (MTIME)
disagreement  in  1  voter any-disagreement flag
fault_flags  in  3  voter per-lane flags, [0]=A [1]=B [2]=C
clear  in  1  sync pulse: reset all statistics/state
irq_ack  in  1  sync pulse: deassert irq
lane_failed  out  3  sticky per-lane failed flags
tmr_state  out  2  00=NORMAL 01=DEGRADED 10=FAILED
fault_cnt_a  out  CNT_W  lane A saturating fault count
fault_cnt_b  out  CNT_W  lane B saturating fault count
fault_cnt_c  out  CNT_W  lane C saturating fault count
time_err  out  1  sticky illegal-MTIME-step flag
irq  out  1  level interrupt

Behaviour:
- Reset (rst_n=0, async): all outputs 0, run counters 0, prev_valid=0, state NORMAL.
- All outputs registered; effect of a sampled input visible 1 cycle later.
- Effective flag ef[i] = fault_flags[i] & disagreement. Flags with disagreement=0 are ignored.
- fault_cnt_x: +1 when ef set; saturates at 2^CNT_W-1 and never wraps.
- Run counter i: ef[i]=1 → min(run+1, PERSIST_THRESH); ef[i]=0 → 0.
- lane_failed[i] sets in the same cycle run reaches PERSIST_THRESH (PERSIST_THRESH=1: first fault). It is sticky until clear.
- State (computed from next-cycle lane_failed):
  - NORMAL: zero failed lanes. → DEGRADED when exactly one lane fails. → FAILED when ≥2 fail, or when ef==3'b111 (no majority).
  - DEGRADED: → FAILED on a second failed lane or ef==3'b111. Never returns to NORMAL except via clear.
  - FAILED: absorbing until clear or reset.
  - Single-cycle jump NORMAL→FAILED is legal when two lanes fail simultaneously.
- MTIME check: keep prev = last voted_value and set prev_valid after the first sample.
  - Legal step when voted_value == prev or prev+1 (mod 2^64; 64'hFFFF_FFFF_FFFF_FFFF→0 is legal).
  - Any other step sets time_err (sticky).
  - No check while prev_valid=0, i.e. the first cycle after reset or clear.
- irq:
  - Sets on any NORMAL→DEGRADED, NORMAL/DEGRADED→FAILED transition, or a time_err 0→1 transition.
  - Clears on irq_ack.
  - If irq_ack and a new set event occur in the same cycle, irq stays 1.
- clear:
  - Synchronously zeroes counters, runs, lane_failed, state, time_err, irq and prev_valid.
  - Has priority over all inputs sampled in the same cycle; that cycle's flags and value are discarded.
- Reset mid-operation: immediate return to reset values; no state retained.

Optional Feature:
Macro TMR_MON_ERRLOG_EN.
- Defined: adds outputs log_valid(1), log_time(64), log_flags(3).
  - On the first effective fault (ef≠0) after reset/clear, captures voted_value and ef, and sets log_valid.
  - Later faults do not overwrite the capture; clear or reset zeroes it.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset with voted_value=5, flags=0 for 10 cycles, incrementing by 1 → tmr_state=00, time_err=0, irq=0, all counts 0.
- disagreement=1, fault_flags=001 for 4 cycles (PERSIST_THRESH=4) → fault_cnt_a=4; lane_failed=001 and tmr_state=01 one cycle after the 4th sample; irq=1. Then irq_ack → irq=0.
- Lane B faults 3 cycles, 1 clean, 3 faulty → lane_failed[1]=0, fault_cnt_b=6, state unchanged.
- ef=111 for one cycle from NORMAL → tmr_state=10 next cycle, irq=1; the following clear pulse → all zero, state 00.
- voted_value steps 64'hFFFF_FFFF_FFFF_FFFF→0 → time_err=0. Then 0x10→0x12 → time_err=1, irq=1. A step in the first cycle after clear is not checked.
- CNT_W=2, lane C faults 6 cycles → fault_cnt_c=3 (saturated). With TMR_MON_ERRLOG_EN, log_time equals the voted_value of the first fault and log_flags=100.

Source files
------------

// File: rtl/tmr_fault_monitor.sv
// tmr_fault_monitor
// Downstream monitor for the 64-bit MTIME TMR voter. Tracks per-lane fault
// statistics, declares lanes failed after persistent faults, sequences the
// TMR health state and checks that the voted MTIME only holds or increments.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   voted_value[63:0]  voter majority output (MTIME)
//   disagreement       voter any-disagreement flag (qualifies fault_flags)
//   fault_flags[2:0]   per-lane flags, [0]=A [1]=B [2]=C
//   clear              sync pulse: zero all statistics/state (wins over inputs)
//   irq_ack            sync pulse: deassert irq
//   lane_failed[2:0]   sticky per-lane failed flags
//   tmr_state[1:0]     00=NORMAL 01=DEGRADED 10=FAILED
//   fault_cnt_a/b/c    per-lane saturating fault counts
//   time_err           sticky illegal-MTIME-step flag
//   irq                level interrupt
//
// Optional feature macro TMR_MON_ERRLOG_EN adds log_valid/log_time/log_flags,
// a one-shot capture of the first effective fault after reset or clear.
module tmr_fault_monitor #(
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned PERSIST_THRESH = 4,
    parameter int unsigned RUN_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [63:0]       voted_value,
    input  logic              disagreement,
    input  logic [2:0]        fault_flags,
    input  logic              clear,
    input  logic              irq_ack,
    output logic [2:0]        lane_failed,
    output logic [1:0]        tmr_state,
    output logic [CNT_W-1:0]  fault_cnt_a,
    output logic [CNT_W-1:0]  fault_cnt_b,
    output logic [CNT_W-1:0]  fault_cnt_c,
    output logic              time_err,
`ifdef TMR_MON_ERRLOG_EN
    output logic              log_valid,
    output logic [63:0]       log_time,
    output logic [2:0]        log_flags,
`endif
    output logic              irq
);

    localparam int unsigned    NLANE      = 3;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [RUN_W-1:0] RUN_THR  = RUN_W'(PERSIST_THRESH);

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'b00,
        ST_DEGRADED = 2'b01,
        ST_FAILED   = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [NLANE];
    logic [CNT_W-1:0] cnt_d [NLANE];
    logic [RUN_W-1:0] run_q [NLANE];
    logic [RUN_W-1:0] run_d [NLANE];
    logic [2:0]       failed_q, failed_d;
    logic             time_err_q, time_err_d;
    logic             irq_q, irq_d;
    logic [63:0]      prev_q, prev_d;
    logic             prev_valid_q, prev_valid_d;
`ifdef TMR_MON_ERRLOG_EN
    logic             log_valid_q, log_valid_d;
    logic [63:0]      log_time_q, log_time_d;
    logic [2:0]       log_flags_q, log_flags_d;
`endif

    logic [2:0] ef;
    logic       multi_fail;
    logic       step_ok;
    logic       irq_set;

    // Flags only count while the voter reports a disagreement.
    assign ef = fault_flags & {3{disagreement}};

    // Next-state: statistics, health FSM, MTIME step check, irq.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        run_d        = run_q;
        failed_d     = failed_q;
        time_err_d   = time_err_q;
        irq_d        = irq_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        multi_fail   = 1'b0;
        step_ok      = 1'b1;
        irq_set      = 1'b0;
`ifdef TMR_MON_ERRLOG_EN
        log_valid_d  = log_valid_q;
        log_time_d   = log_time_q;
        log_flags_d  = log_flags_q;
`endif

        if (clear) begin
            state_d      = ST_NORMAL;
            for (int i = 0; i < NLANE; i++) begin
                cnt_d[i] = '0;
                run_d[i] = '0;
            end
            failed_d     = '0;
            time_err_d   = 1'b0;
            irq_d        = 1'b0;
            prev_d       = '0;
            prev_valid_d = 1'b0;
`ifdef TMR_MON_ERRLOG_EN
            log_valid_d  = 1'b0;
            log_time_d   = '0;
            log_flags_d  = '0;
`endif
        end else begin
            for (int i = 0; i < NLANE; i++) begin
                if (ef[i]) begin
                    if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    run_d[i] = (run_q[i] >= RUN_THR) ? RUN_THR : run_q[i] + RUN_W'(1);
                    if (run_d[i] == RUN_THR) failed_d[i] = 1'b1;
                end else begin
                    run_d[i] = '0;
                end
            end

            multi_fail = (failed_d[0] & failed_d[1]) | (failed_d[0] & failed_d[2]) |
                         (failed_d[1] & failed_d[2]);

            // Health is judged on the failed set as it will be next cycle.
            case (state_q)
                ST_NORMAL: begin
                    if (multi_fail || ef == 3'b111) state_d = ST_FAILED;
                    else if (|failed_d)             state_d = ST_DEGRADED;
                end
                ST_DEGRADED: begin
                    if (multi_fail || ef == 3'b111) state_d = ST_FAILED;
                end
                default: state_d = ST_FAILED;
            endcase

            // Hold or +1 (wrapping) are the only legal MTIME steps.
            step_ok = (voted_value == prev_q) || (voted_value == prev_q + 64'd1);
            if (prev_valid_q && !step_ok) time_err_d = 1'b1;
            prev_d       = voted_value;
            prev_valid_d = 1'b1;

            irq_set = (state_d != state_q) || (time_err_d && !time_err_q);
            if (irq_set)      irq_d = 1'b1;
            else if (irq_ack) irq_d = 1'b0;

`ifdef TMR_MON_ERRLOG_EN
            if (!log_valid_q && ef != 3'b000) begin
                log_valid_d = 1'b1;
                log_time_d  = voted_value;
                log_flags_d = ef;
            end
`endif
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_NORMAL;
            for (int i = 0; i < NLANE; i++) begin
                cnt_q[i] <= '0;
                run_q[i] <= '0;
            end
            failed_q     <= '0;
            time_err_q   <= 1'b0;
            irq_q        <= 1'b0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
`ifdef TMR_MON_ERRLOG_EN
            log_valid_q  <= 1'b0;
            log_time_q   <= '0;
            log_flags_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            for (int i = 0; i < NLANE; i++) begin
                cnt_q[i] <= cnt_d[i];
                run_q[i] <= run_d[i];
            end
            failed_q     <= failed_d;
            time_err_q   <= time_err_d;
            irq_q        <= irq_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
`ifdef TMR_MON_ERRLOG_EN
            log_valid_q  <= log_valid_d;
            log_time_q   <= log_time_d;
            log_flags_q  <= log_flags_d;
`endif
        end
    end

    assign lane_failed = failed_q;
    assign tmr_state   = state_q;
    assign fault_cnt_a = cnt_q[0];
    assign fault_cnt_b = cnt_q[1];
    assign fault_cnt_c = cnt_q[2];
    assign time_err    = time_err_q;
    assign irq         = irq_q;
`ifdef TMR_MON_ERRLOG_EN
    assign log_valid   = log_valid_q;
    assign log_time    = log_time_q;
    assign log_flags   = log_flags_q;
`endif

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Bench for tmr_fault_monitor: directed vectors, a behavioural model checked
// every cycle, and literal expectations at the key points of each scenario.
// Built with CNT_W=3 so saturation (7) is reachable in a few cycles.
module tb_tmr_fault_monitor;

    localparam int CW      = 3;
    localparam int TH      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk, rst_n;
    logic [63:0]   voted_value;
    logic          disagreement, clear, irq_ack;
    logic [2:0]    fault_flags;
    logic [2:0]    lane_failed;
    logic [1:0]    tmr_state;
    logic [CW-1:0] fault_cnt_a, fault_cnt_b, fault_cnt_c;
    logic          time_err, irq;
`ifdef TMR_MON_ERRLOG_EN
    logic          log_valid;
    logic [63:0]   log_time;
    logic [2:0]    log_flags;
`endif

    tmr_fault_monitor #(.CNT_W(CW), .PERSIST_THRESH(TH), .RUN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .voted_value(voted_value),
        .disagreement(disagreement), .fault_flags(fault_flags),
        .clear(clear), .irq_ack(irq_ack), .lane_failed(lane_failed),
        .tmr_state(tmr_state), .fault_cnt_a(fault_cnt_a),
        .fault_cnt_b(fault_cnt_b), .fault_cnt_c(fault_cnt_c),
        .time_err(time_err),
`ifdef TMR_MON_ERRLOG_EN
        .log_valid(log_valid), .log_time(log_time), .log_flags(log_flags),
`endif
        .irq(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int          m_cnt [3];
    int          m_run [3];
    logic [2:0]  m_failed;
    int          m_state;     // 0 normal, 1 degraded, 2 failed
    logic        m_terr, m_irq, m_pv, m_lv;
    logic [63:0] m_prev, m_lt;
    logic [2:0]  m_lf;
    logic [63:0] tv;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            m_run[i] = 0;
        end
        m_failed = 3'b000; m_state = 0; m_terr = 0; m_irq = 0;
        m_pv = 0; m_prev = '0; m_lv = 0; m_lt = '0; m_lf = 3'b000;
    endtask

    task automatic model_step(input logic [63:0] v, input logic d, input logic [2:0] f,
                              input logic clr, input logic ack);
        logic [2:0] e;
        int nf, old;
        logic step_bad, set;
        if (clr) begin
            model_reset();
        end else begin
            e = f & {3{d}};
            for (int i = 0; i < 3; i++) begin
                if (e[i]) begin
                    if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
                    if (m_run[i] < TH) m_run[i]++;
                    if (m_run[i] == TH) m_failed[i] = 1'b1;
                end else begin
                    m_run[i] = 0;
                end
            end
            nf  = int'(m_failed[0]) + int'(m_failed[1]) + int'(m_failed[2]);
            old = m_state;
            if (m_state != 2 && (nf >= 2 || e == 3'b111)) m_state = 2;
            else if (m_state == 0 && nf == 1)             m_state = 1;
            step_bad = m_pv && (v != m_prev) && (v != m_prev + 64'd1);
            set = (m_state != old) || (step_bad && !m_terr);
            if (step_bad) m_terr = 1'b1;
            if (set)      m_irq = 1'b1;
            else if (ack) m_irq = 1'b0;
            m_prev = v;
            m_pv   = 1'b1;
            if (!m_lv && e != 3'b000) begin
                m_lv = 1'b1; m_lt = v; m_lf = e;
            end
        end
    endtask

    task automatic compare_all();
        check("lane_failed", 64'(lane_failed), 64'(m_failed));
        check("tmr_state", 64'(tmr_state), 64'(m_state));
        check("fault_cnt_a", 64'(fault_cnt_a), 64'(m_cnt[0]));
        check("fault_cnt_b", 64'(fault_cnt_b), 64'(m_cnt[1]));
        check("fault_cnt_c", 64'(fault_cnt_c), 64'(m_cnt[2]));
        check("time_err", 64'(time_err), 64'(m_terr));
        check("irq", 64'(irq), 64'(m_irq));
`ifdef TMR_MON_ERRLOG_EN
        check("log_valid", 64'(log_valid), 64'(m_lv));
        check("log_time", log_time, m_lt);
        check("log_flags", 64'(log_flags), 64'(m_lf));
`endif
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic cyc(input logic [63:0] v, input logic d, input logic [2:0] f,
                       input logic clr, input logic ack);
        voted_value = v; disagreement = d; fault_flags = f; clear = clr; irq_ack = ack;
        @(posedge clk);
        model_step(v, d, f, clr, ack);
        @(negedge clk);
        compare_all();
    endtask

    // Incrementing MTIME with the given flags for n cycles.
    task automatic run(input int n, input logic d, input logic [2:0] f);
        for (int i = 0; i < n; i++) begin
            cyc(tv, d, f, 1'b0, 1'b0);
            tv = tv + 64'd1;
        end
    endtask

    initial begin
        rst_n = 1'b0; voted_value = 64'd5; disagreement = 1'b0;
        fault_flags = 3'b000; clear = 1'b0; irq_ack = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        check("rst_state", 64'(tmr_state), 64'd0);
        rst_n = 1'b1;

        // Clean incrementing MTIME
        tv = 64'd5;
        run(10, 1'b0, 3'b000);
        check("clean_state", 64'(tmr_state), 64'd0);
        check("clean_terr", 64'(time_err), 64'd0);
        check("clean_irq", 64'(irq), 64'd0);

        // Lane A persistent fault
        run(3, 1'b1, 3'b001);
        check("a3_failed", 64'(lane_failed), 64'd0);
        run(1, 1'b1, 3'b001);
        check("a4_cnt", 64'(fault_cnt_a), 64'd4);
        check("a4_failed", 64'(lane_failed), 64'b001);
        check("a4_state", 64'(tmr_state), 64'd1);
        check("a4_irq", 64'(irq), 64'd1);
        cyc(tv, 1'b0, 3'b000, 1'b0, 1'b1); tv = tv + 64'd1;
        check("ack_irq", 64'(irq), 64'd0);

        // Lane B interrupted runs never reach the threshold
        run(3, 1'b1, 3'b010);
        run(1, 1'b0, 3'b000);
        run(3, 1'b1, 3'b010);
        check("b_failed", 64'(lane_failed), 64'b001);
        check("b_cnt", 64'(fault_cnt_b), 64'd6);
        check("b_state", 64'(tmr_state), 64'd1);

        // Flags without disagreement are ignored
        run(5, 1'b0, 3'b111);
        check("nodis_cnt_a", 64'(fault_cnt_a), 64'd4);
        check("nodis_state", 64'(tmr_state), 64'd1);

        // Clear wins over same-cycle faults
        cyc(tv, 1'b1, 3'b111, 1'b1, 1'b0); tv = tv + 64'd1;
        check("clr_state", 64'(tmr_state), 64'd0);
        check("clr_cnt_a", 64'(fault_cnt_a), 64'd0);
        check("clr_failed", 64'(lane_failed), 64'd0);

        // No majority from NORMAL
        run(1, 1'b1, 3'b111);
        check("nomaj_state", 64'(tmr_state), 64'd2);
        check("nomaj_irq", 64'(irq), 64'd1);
        cyc(tv, 1'b0, 3'b000, 1'b1, 1'b0); tv = tv + 64'd1;
        check("clr2_state", 64'(tmr_state), 64'd0);
        check("clr2_irq", 64'(irq), 64'd0);

        // Two lanes fail together; ack collides with the set event
        run(3, 1'b1, 3'b011);
        cyc(tv, 1'b1, 3'b011, 1'b0, 1'b1); tv = tv + 64'd1;
        check("ab_state", 64'(tmr_state), 64'd2);
        check("ab_failed", 64'(lane_failed), 64'b011);
        check("ab_irq", 64'(irq), 64'd1);
        cyc(tv, 1'b0, 3'b000, 1'b1, 1'b0);

        // MTIME wraparound is legal
        cyc(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 3'b000, 1'b0, 1'b0);
        cyc(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'b000, 1'b0, 1'b0);
        cyc(64'h0, 1'b0, 3'b000, 1'b0, 1'b0);
        cyc(64'h0, 1'b0, 3'b000, 1'b0, 1'b0);
        check("wrap_terr", 64'(time_err), 64'd0);
        cyc(64'h10, 1'b0, 3'b000, 1'b1, 1'b0);
        cyc(64'h10, 1'b0, 3'b000, 1'b0, 1'b0);
        cyc(64'h12, 1'b0, 3'b000, 1'b0, 1'b0);
        check("skip_terr", 64'(time_err), 64'd1);
        check("skip_irq", 64'(irq), 64'd1);

        // First sample after clear is not checked
        cyc(64'h12, 1'b0, 3'b000, 1'b1, 1'b0);
        cyc(64'h500, 1'b0, 3'b000, 1'b0, 1'b0);
        cyc(64'h501, 1'b0, 3'b000, 1'b0, 1'b0);
        check("postclr_terr", 64'(time_err), 64'd0);

        // Lane C saturation and first-fault capture
        tv = 64'h502;
        run(10, 1'b1, 3'b100);
        check("c_cnt_sat", 64'(fault_cnt_c), 64'd7);
        check("c_failed", 64'(lane_failed), 64'b100);
        check("c_state", 64'(tmr_state), 64'd1);
        run(1, 1'b1, 3'b001);
`ifdef TMR_MON_ERRLOG_EN
        check("log_time_lit", log_time, 64'h502);
        check("log_flags_lit", 64'(log_flags), 64'b100);
`endif

        // Asynchronous reset mid-operation
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("midrst_failed", 64'(lane_failed), 64'd0);
        check("midrst_cnt_c", 64'(fault_cnt_c), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(2, 1'b0, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
